// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master (plus HREADY multiplexor) and the SRAM slave.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a word-organised SRAM with byte-lane writes,
// configurable wait states and the two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_sram_slave_if.slave bus
);

    localparam int unsigned BYTE_AW = ADDR_WIDTH + 2;
    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    typedef struct packed {
        logic               active;
        logic               write;
        logic [2:0]         size;
        logic [BYTE_AW-1:0] addr;
        logic               err;
    } dphase_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    dphase_t            dp_q, dp_d;
    logic               hreadyout_c, hresp_c;
    logic               wr_en_c, rd_en_c;
    logic [3:0]         lanes_c;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]        mem [DEPTH];
    logic               unused_inputs;

    assign unused_inputs = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

    // Address-phase decode, including the legality check
    always_comb begin
        dp_d        = '0;
        dp_d.active = bus.HSEL & bus.HTRANS[1];
        dp_d.write  = bus.HWRITE;
        dp_d.size   = bus.HSIZE;
        dp_d.addr   = bus.HADDR[BYTE_AW-1:0];
        dp_d.err    = dp_d.active &
                      ((bus.HSIZE > 3'b010) ||
                       (bus.HSIZE == 3'b001 && bus.HADDR[0]) ||
                       (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00) ||
                       (|bus.HADDR[31:BYTE_AW]));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_q <= '0;
        end else if (bus.HREADY) begin
            dp_q <= dp_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and response decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_c = 1'b1;
        hresp_c     = 1'b0;
        case (state_q)
            S_IDLE, S_ERR2: begin
                hresp_c = (state_q == S_ERR2);
                if (bus.HREADY) begin
                    if (dp_d.err) begin
                        state_d = S_ERR1;
                    end else if (dp_d.active && WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                hreadyout_c = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 1'b1;
                state_d     = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'b000:  return 4'(4'b0001 << a);
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign word_idx = dp_q.addr[BYTE_AW-1:2];
    assign lanes_c  = lane_mask(dp_q.size, dp_q.addr[1:0]);
    assign wr_en_c  = (state_q == S_IDLE) & dp_q.active & dp_q.write & ~dp_q.err & ~HRESET;
    assign rd_en_c  = dp_q.active & ~dp_q.write & ~dp_q.err;

    // Write commits on the edge that closes the data phase; storage is never reset
    always_ff @(posedge HCLK) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_c[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = rd_en_c ? mem[word_idx] : 32'h0;
    assign bus.HREADYOUT = hreadyout_c;
    assign bus.HRESP     = hresp_c;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: a zero-wait slave driven from a per-cycle vector table, and a
// two-wait-state slave exercised with hand sequences (waits, INCR4, reset mid-wait).
module tb_ahb_lite_sram_slave;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SQ  = 2'b11;
    localparam int unsigned NV = 26;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    logic HCLK;
    logic rst0, rst2;
    int   total, bad;
    vec_t vt [NV];

    ahb_lite_sram_slave_if b0 ();
    ahb_lite_sram_slave_if b2 ();

    assign b0.HREADY = b0.HREADYOUT;
    assign b2.HREADY = b2.HREADYOUT;

    ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(rst0), .bus(b0)
    );
    ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (
        .HCLK(HCLK), .HRESET(rst2), .bus(b2)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic rdy,
                                input logic resp, input logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a;
        v.wdata = wd; v.rdy = rdy; v.resp = resp; v.rdata = rd;
        return v;
    endfunction

    task automatic drv0(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] a);
        b0.HSEL = sel; b0.HTRANS = tr; b0.HWRITE = wr; b0.HSIZE = sz; b0.HADDR = a;
        b0.HBURST = 3'b001; b0.HPROT = 4'b0011; b0.HMASTLOCK = 1'b0;
    endtask

    task automatic drv2(input logic [1:0] tr, input logic wr, input logic [31:0] a);
        b2.HSEL = 1'b1; b2.HTRANS = tr; b2.HWRITE = wr; b2.HSIZE = 3'b010; b2.HADDR = a;
        b2.HBURST = 3'b011; b2.HPROT = 4'b0011; b2.HMASTLOCK = 1'b0;
    endtask

    // Counts HREADYOUT-low cycles of the current data phase; returns at the ready negedge
    task automatic wait_rdy2(output int low);
        low = 0;
        @(negedge HCLK);
        while (b2.HREADYOUT !== 1'b1 && low < 20) begin
            low++;
            @(negedge HCLK);
        end
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d);
        int low;
        drv2(NSQ, 1'b1, a);
        @(posedge HCLK); #1;
        drv2(IDL, 1'b0, 32'h0);
        b2.HWDATA = d;
        wait_rdy2(low);
        chk($sformatf("wr2 waits @%h", a), 32'(low), 32'd2);
        chk($sformatf("wr2 resp @%h", a), 32'(b2.HRESP), 32'd0);
        @(posedge HCLK); #1;
    endtask

    task automatic rd2(input logic [31:0] a, input logic [31:0] exp);
        int low;
        drv2(NSQ, 1'b0, a);
        @(posedge HCLK); #1;
        drv2(IDL, 1'b0, 32'h0);
        wait_rdy2(low);
        chk($sformatf("rd2 waits @%h", a), 32'(low), 32'd2);
        chk($sformatf("rd2 data @%h", a), b2.HRDATA, exp);
        @(posedge HCLK); #1;
    endtask

    initial begin
        logic [31:0] beat_data [4];
        int low;
        total = 0;
        bad   = 0;

        // One row per cycle: address phase inputs, HWDATA for the data phase in
        // flight, and the slave outputs expected during that cycle.
        vt[0]  = mk(1, NSQ, 1, 3'd2, 32'h000,  32'h0,        1, 0, 32'h0);
        vt[1]  = mk(1, NSQ, 1, 3'd2, 32'h010,  32'h0BADF00D, 1, 0, 32'h0);
        vt[2]  = mk(1, NSQ, 0, 3'd2, 32'h010,  32'hDEADBEEF, 1, 0, 32'h0);
        vt[3]  = mk(1, NSQ, 1, 3'd2, 32'h010,  32'h0,        1, 0, 32'hDEADBEEF);
        vt[4]  = mk(1, NSQ, 1, 3'd0, 32'h013,  32'h11223344, 1, 0, 32'h0);
        vt[5]  = mk(1, NSQ, 0, 3'd2, 32'h010,  32'hAA000000, 1, 0, 32'h0);
        vt[6]  = mk(1, NSQ, 1, 3'd1, 32'h010,  32'h0,        1, 0, 32'hAA223344);
        vt[7]  = mk(1, NSQ, 0, 3'd2, 32'h010,  32'h00005566, 1, 0, 32'h0);
        vt[8]  = mk(1, NSQ, 1, 3'd2, 32'h014,  32'h0,        1, 0, 32'hAA225566);
        vt[9]  = mk(1, SQ,  1, 3'd2, 32'h018,  32'hC0FFEE14, 1, 0, 32'h0);
        vt[10] = mk(0, NSQ, 1, 3'd2, 32'h010,  32'hC0FFEE18, 1, 0, 32'h0);
        vt[11] = mk(1, NSQ, 0, 3'd2, 32'h010,  32'h12345678, 1, 0, 32'h0);
        vt[12] = mk(1, SQ,  0, 3'd2, 32'h014,  32'h0,        1, 0, 32'hAA225566);
        vt[13] = mk(1, BSY, 0, 3'd2, 32'h018,  32'h0,        1, 0, 32'hC0FFEE14);
        vt[14] = mk(1, SQ,  0, 3'd2, 32'h018,  32'h0,        1, 0, 32'h0);
        vt[15] = mk(1, NSQ, 1, 3'd2, 32'h002,  32'h0,        1, 0, 32'hC0FFEE18);
        vt[16] = mk(1, IDL, 0, 3'd2, 32'h0,    32'hFFFFFFFF, 0, 1, 32'h0);
        vt[17] = mk(1, IDL, 0, 3'd2, 32'h0,    32'h0,        1, 1, 32'h0);
        vt[18] = mk(1, NSQ, 1, 3'd3, 32'h000,  32'h0,        1, 0, 32'h0);
        vt[19] = mk(1, IDL, 0, 3'd2, 32'h0,    32'hFFFFFFFF, 0, 1, 32'h0);
        vt[20] = mk(1, IDL, 0, 3'd2, 32'h0,    32'h0,        1, 1, 32'h0);
        vt[21] = mk(1, NSQ, 1, 3'd2, 32'h1000, 32'h0,        1, 0, 32'h0);
        vt[22] = mk(1, IDL, 0, 3'd2, 32'h0,    32'hFFFFFFFF, 0, 1, 32'h0);
        vt[23] = mk(1, IDL, 0, 3'd2, 32'h0,    32'h0,        1, 1, 32'h0);
        vt[24] = mk(1, NSQ, 0, 3'd2, 32'h000,  32'h0,        1, 0, 32'h0);
        vt[25] = mk(1, IDL, 0, 3'd2, 32'h0,    32'h0,        1, 0, 32'h0BADF00D);

        for (int k = 0; k < 4; k++) beat_data[k] = 32'h11110000 + 32'(k);

        rst0 = 1'b1;
        rst2 = 1'b1;
        drv0(1'b0, IDL, 1'b0, 3'd2, 32'h0);
        drv2(IDL, 1'b0, 32'h0);
        b0.HWDATA = 32'h0;
        b2.HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        rst0 = 1'b0;
        rst2 = 1'b0;

        @(negedge HCLK);
        chk("reset0 hreadyout", 32'(b0.HREADYOUT), 32'd1);
        chk("reset0 hresp", 32'(b0.HRESP), 32'd0);
        chk("reset0 hrdata", b0.HRDATA, 32'h0);
        chk("reset2 hreadyout", 32'(b2.HREADYOUT), 32'd1);
        chk("reset2 hresp", 32'(b2.HRESP), 32'd0);
        chk("reset2 hrdata", b2.HRDATA, 32'h0);
        @(posedge HCLK); #1;

        for (int i = 0; i < int'(NV); i++) begin
            drv0(vt[i].sel, vt[i].trans, vt[i].wr, vt[i].size, vt[i].addr);
            b0.HWDATA = vt[i].wdata;
            @(negedge HCLK);
            chk($sformatf("row%0d hreadyout", i), 32'(b0.HREADYOUT), 32'(vt[i].rdy));
            chk($sformatf("row%0d hresp", i), 32'(b0.HRESP), 32'(vt[i].resp));
            chk($sformatf("row%0d hrdata", i), b0.HRDATA, vt[i].rdata);
            @(posedge HCLK); #1;
        end

        for (int k = 0; k < 4; k++) wr2(32'(4 * k), beat_data[k]);

        // INCR4 read: next beat's address is held while the current beat waits
        drv2(NSQ, 1'b0, 32'h0);
        @(posedge HCLK); #1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drv2(SQ, 1'b0, 32'(4 * (k + 1)));
            else       drv2(IDL, 1'b0, 32'h0);
            wait_rdy2(low);
            chk($sformatf("incr4 beat%0d waits", k), 32'(low), 32'd2);
            chk($sformatf("incr4 beat%0d data", k), b2.HRDATA, beat_data[k]);
            @(posedge HCLK); #1;
        end

        // Reset lands in the second wait cycle of a write to word 1
        drv2(NSQ, 1'b1, 32'h4);
        @(posedge HCLK); #1;
        drv2(IDL, 1'b0, 32'h0);
        b2.HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        chk("rst-wait first wait", 32'(b2.HREADYOUT), 32'd0);
        @(posedge HCLK); #1;
        chk("rst-wait second wait", 32'(b2.HREADYOUT), 32'd0);
        rst2 = 1'b1;
        @(posedge HCLK); #1;
        rst2 = 1'b0;
        @(negedge HCLK);
        chk("rst-wait hreadyout", 32'(b2.HREADYOUT), 32'd1);
        chk("rst-wait hresp", 32'(b2.HRESP), 32'd0);
        chk("rst-wait hrdata", b2.HRDATA, 32'h0);
        @(posedge HCLK); #1;
        rd2(32'h4, beat_data[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite slave holding a word-organised on-chip SRAM; the downstream consumer of the transfers issued by the team's AHB-Lite master. It accepts NONSEQ/SEQ transfers of every burst type, supports byte, halfword and word writes via byte lanes, and inserts a configurable number of wait states. Illegal transfers get the two-cycle AHB ERROR response.

## Interface
- ADDR_WIDTH, 10: word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words. Byte range is 0 .. 4*2**ADDR_WIDTH-1.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in the data phase of every accepted OKAY transfer (0..15).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored, because the master supplies each address.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready from the multiplexor.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Address phase sampling**
  - Sampling happens on any rising edge with HREADY=1.
  - The transfer is active if HSEL=1 and HTRANS[1]=1.
  - Captured: active flag, HWRITE, HSIZE, HADDR[ADDR_WIDTH+1:0] and an error flag.
  - With HREADY=0 nothing is sampled and the pending data phase continues.
- **Error flag** is set on any of the following:
  - HSIZE > 3'b010.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0] != 0.
  - HADDR[31:ADDR_WIDTH+2] != 0.
- **State machine**
  - States: IDLE, WAIT, ERR1, ERR2.
  - IDLE is the zero-wait data-phase state. It emits HREADYOUT=1, HRESP=0.
  - On a sample edge:
    - error flag set → ERR1.
    - active, no error, WAIT_STATES>0 → WAIT, with the counter loaded to WAIT_STATES-1.
    - otherwise → IDLE.
  - WAIT emits HREADYOUT=0, HRESP=0. The counter decrements each cycle. Exit to IDLE when the counter is 0.
  - ERR1 emits HREADYOUT=0, HRESP=1 and always goes to ERR2.
  - ERR2 emits HREADYOUT=1, HRESP=1. It is a sample edge, so the next state is chosen by the rules above.
- **Inactive transfers** (IDLE, BUSY, or HSEL=0) get a zero-wait OKAY data phase. Memory is untouched.
- **Write**
  - Performed on the edge that ends the data phase, i.e. when the slave is in IDLE and HREADYOUT=1 for an active, error-free write.
  - Byte lanes come from the captured size and address bits:
    - byte: lane HADDR[1:0].
    - halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
    - word: all four lanes.
  - Only the enabled lanes of the word are written. Erroring writes never modify memory.
- **Read**
  - HRDATA = mem[captured word address], combinational, during the data phase of an active, error-free read. All 32 bits are driven regardless of size.
  - HRDATA = 0 otherwise.
- **Read after write**
  - A read whose address phase overlaps the previous write's data phase returns the newly written data.
  - This holds because the write completes before the read's data phase begins.
- **Memory contents** are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0, captured active=0.
- HRESET overrides everything. Any in-progress wait or error sequence is abandoned and no pending write is performed.
- Zero-wait latency:
  - The address phase is at edge N.
  - Read data is valid during cycle N..N+1.
  - The write is committed at edge N+1.
- With WAIT_STATES=W, the data phase lasts W+1 cycles, with HREADYOUT low for exactly W cycles.
- An error data phase is always 2 cycles. HRESP=1 is held for both; HREADYOUT is 0 then 1.
- Back-to-back bursts (SEQ every cycle at zero wait) run at one transfer per cycle.
- A BUSY inside a burst is a zero-wait OKAY. The following SEQ is processed normally.

## Test plan
- Reset → HREADYOUT=1, HRESP=0, HRDATA=0.
- Word write 0xDEADBEEF @0x10, then word read @0x10 issued pipelined in the next cycle → HRDATA=0xDEADBEEF in the read data phase, zero waits.
- Byte write 0xAA at 0x13 over existing word 0x11223344 (HWDATA=0xAA000000) → word reads 0xAA223344. Halfword write 0x5566 at 0x10 → word reads 0xAA225566.
- WAIT_STATES=2, INCR4 read @0x0 → each beat has HREADYOUT low for exactly 2 cycles; data for words 0..3 is returned in order.
- Illegal cases → HRESP=1 for 2 cycles with HREADYOUT 0 then 1, and memory unchanged. Each is checked separately:
  - word write @0x2 (misaligned).
  - HSIZE=3'b011.
  - address 0x1000 with ADDR_WIDTH=10 (out of range).
- HRESET asserted during the second wait cycle of a write → next cycle HREADYOUT=1, HRESP=0, and the target word is unchanged.
